// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: register-file write-port arbiter and per-register load scoreboard
module reg_writeback_ctrl #(
   parameter int LD_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_wen,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ld_issue,
   input  logic [4:0]  ld_rd,
   output logic        ld_issue_ready,
   input  logic        ld_resp_valid,
   input  logic [31:0] ld_resp_data,
   output logic        ld_resp_ready,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic        rs1_busy,
   output logic        rs2_busy,
   output logic        RegWEn,
   output logic [4:0]  AddrD,
   output logic [31:0] DataD,
   output logic [1:0]  wb_err
);
   localparam int AW = $clog2(LD_DEPTH);
   localparam int CW = $clog2(LD_DEPTH + 1);
   logic [4:0]    fifo [LD_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] pending [32];
   logic [CW-1:0] pend_nxt [32];
   logic          hold_valid, from_load;
   logic [4:0]    hold_rd, sel_rd;
   logic [31:0]   hold_data, sel_data;
   logic          push, resp_acc, pop, sel_valid;
   assign ld_issue_ready = cnt != CW'(LD_DEPTH);
   assign ld_resp_ready  = !hold_valid;
   assign push     = ld_issue && ld_issue_ready;
   assign resp_acc = ld_resp_valid && ld_resp_ready;
   assign pop      = resp_acc && cnt != '0;
   assign rs1_busy = rs1_addr != 5'd0 && (pending[rs1_addr] != '0 || (RegWEn && AddrD == rs1_addr));
   assign rs2_busy = rs2_addr != 5'd0 && (pending[rs2_addr] != '0 || (RegWEn && AddrD == rs2_addr));
   // write-port priority: ALU, then held response, then a fresh response
   always_comb begin
      sel_valid = alu_wen || hold_valid || pop;
      sel_rd    = alu_wen ? alu_rd : hold_valid ? hold_rd : fifo[rptr];
      sel_data  = alu_wen ? alu_data : hold_valid ? hold_data : ld_resp_data;
   end
   // pending count per register: +1 on load issue, -1 when its write commits
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         pend_nxt[i] = pending[i];
         if (push && i != 0 && ld_rd == 5'(i)) pend_nxt[i] = pend_nxt[i] + CW'(1);
         if (RegWEn && from_load && AddrD == 5'(i)) pend_nxt[i] = pend_nxt[i] - CW'(1);
      end
   end
   // destination-tag storage; contents are don't-care while empty so no reset
   always_ff @(posedge clk) begin
      if (push) fifo[wptr] <= ld_rd;
   end
   // fifo pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         wptr <= wptr + AW'(push);
         rptr <= rptr + AW'(pop);
         cnt  <= cnt + CW'(push) - CW'(pop);
      end
   end
   // hold captures a response that lost the port to the ALU, drains on the first ALU-free cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_rd    <= '0;
         hold_data  <= '0;
      end else if (pop && alu_wen) begin
         hold_valid <= 1'b1;
         hold_rd    <= fifo[rptr];
         hold_data  <= ld_resp_data;
      end else if (!alu_wen) begin
         hold_valid <= 1'b0;
      end
   end
   // registered write port; writes to x0 never assert the enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWEn    <= 1'b0;
         AddrD     <= '0;
         DataD     <= '0;
         from_load <= 1'b0;
      end else begin
         RegWEn    <= sel_valid && sel_rd != 5'd0;
         from_load <= sel_valid && !alu_wen;
         if (sel_valid) begin
            AddrD <= sel_rd;
            DataD <= sel_data;
         end
      end
   end
   // scoreboard counters and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) pending[i] <= '0;
         wb_err <= '0;
      end else begin
         pending <= pend_nxt;
         wb_err  <= wb_err | {resp_acc && cnt == '0, alu_wen && alu_rd != 5'd0 && pending[alu_rd] != '0};
      end
   end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: scoreboard bench for the write-port controller
module tb_reg_writeback_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_wen = 1'b0;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        ld_issue = 1'b0;
   logic [4:0]  ld_rd = '0;
   logic        ld_issue_ready;
   logic        ld_resp_valid = 1'b0;
   logic [31:0] ld_resp_data = '0;
   logic        ld_resp_ready;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic        rs1_busy, rs2_busy;
   logic        RegWEn;
   logic [4:0]  AddrD;
   logic [31:0] DataD;
   logic [1:0]  wb_err;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [36:0] exp_q [$];

   reg_writeback_ctrl #(.LD_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_wen(alu_wen), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_issue_ready(ld_issue_ready),
      .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_ready(ld_resp_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .RegWEn(RegWEn), .AddrD(AddrD), .DataD(DataD), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
      exp_q.push_back({rd, d});
   endtask

   task automatic resp(input logic [31:0] d);
      ld_resp_valid = 1'b1;
      ld_resp_data  = d;
      step();
      ld_resp_valid = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd);
      ld_issue = 1'b1;
      ld_rd    = rd;
      step();
      ld_issue = 1'b0;
   endtask

   // every write on the port must match the oldest expected write
   always @(negedge clk) begin
      if (rst_n && RegWEn) begin
         if (exp_q.size() == 0) chk("unexp_wr", 64'(RegWEn), 64'd0);
         else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", 64'(AddrD), 64'(e[36:32]));
            chk("wr_data", 64'(DataD), 64'(e[31:0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      step();
      step();
      chk("rst_issue_rdy", 64'(ld_issue_ready), 64'd1);
      chk("rst_resp_rdy", 64'(ld_resp_ready), 64'd1);
      chk("rst_wen", 64'(RegWEn), 64'd0);
      chk("rst_addr", 64'(AddrD), 64'd0);
      chk("rst_data", 64'(DataD), 64'd0);
      chk("rst_err", 64'(wb_err), 64'd0);
      chk("rst_busy", 64'(rs1_busy), 64'd0);
      rst_n = 1'b1;
      step();
      // ALU write and busy window
      rs1_addr = 5'd5;
      alu_wen = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      exp_wr(5'd5, 32'hDEADBEEF);
      step();
      alu_wen = 1'b0;
      chk("alu_wen", 64'(RegWEn), 64'd1);
      chk("alu_busy_n1", 64'(rs1_busy), 64'd1);
      step();
      chk("alu_busy_n2", 64'(rs1_busy), 64'd0);
      // simple load
      rs1_addr = 5'd7;
      issue(5'd7);
      chk("ld_busy", 64'(rs1_busy), 64'd1);
      step();
      step();
      exp_wr(5'd7, 32'h1234);
      resp(32'h1234);
      chk("ld_busy_wr", 64'(rs1_busy), 64'd1);
      step();
      chk("ld_busy_clr", 64'(rs1_busy), 64'd0);
      // response colliding with ALU write
      issue(5'd9);
      issue(5'd10);
      alu_wen = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
      exp_wr(5'd3, 32'h33);
      exp_wr(5'd9, 32'hA9);
      resp(32'hA9);
      alu_wen = 1'b0;
      chk("hold_rdy0", 64'(ld_resp_ready), 64'd0);
      ld_resp_valid = 1'b1; ld_resp_data = 32'hAA;
      step();
      chk("hold_rdy1", 64'(ld_resp_ready), 64'd1);
      exp_wr(5'd10, 32'hAA);
      step();
      ld_resp_valid = 1'b0;
      step();
      step();
      // fill the fifo, overflow issue ignored
      for (int i = 1; i <= 4; i++) issue(5'(i));
      chk("full_rdy", 64'(ld_issue_ready), 64'd0);
      rs2_addr = 5'd6;
      issue(5'd6);
      chk("ovf_busy", 64'(rs2_busy), 64'd0);
      rs1_addr = 5'd1; rs2_addr = 5'd2;
      for (int i = 1; i <= 4; i++) exp_wr(5'(i), 32'hA0 + 32'(i));
      resp(32'hA1);
      chk("drain_b1", 64'(rs1_busy), 64'd1);
      resp(32'hA2);
      chk("drain_b1c", 64'(rs1_busy), 64'd0);
      chk("drain_b2", 64'(rs2_busy), 64'd1);
      chk("drain_rdy", 64'(ld_issue_ready), 64'd1);
      resp(32'hA3);
      chk("drain_b2c", 64'(rs2_busy), 64'd0);
      resp(32'hA4);
      step();
      step();
      // issue while full in the same cycle as a response
      for (int i = 11; i <= 14; i++) issue(5'(i));
      rs2_addr = 5'd15;
      ld_issue = 1'b1; ld_rd = 5'd15;
      exp_wr(5'd11, 32'hB1);
      resp(32'hB1);
      ld_issue = 1'b0;
      chk("full_pop_busy", 64'(rs2_busy), 64'd0);
      chk("full_pop_rdy", 64'(ld_issue_ready), 64'd1);
      for (int i = 12; i <= 14; i++) begin
         exp_wr(5'(i), 32'hB0 + 32'(i - 10));
         resp(32'hB0 + 32'(i - 10));
      end
      step();
      step();
      // WAW and orphan response errors
      issue(5'd2);
      alu_wen = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
      exp_wr(5'd2, 32'h22);
      step();
      alu_wen = 1'b0;
      chk("err_waw", 64'(wb_err), 64'd1);
      exp_wr(5'd2, 32'h2B);
      resp(32'h2B);
      step();
      chk("err_sticky", 64'(wb_err), 64'd1);
      resp(32'hBAD);
      chk("err_orphan", 64'(wb_err), 64'd3);
      step();
      // x0 traffic never writes or marks busy
      rs1_addr = 5'd0;
      issue(5'd0);
      chk("x0_busy", 64'(rs1_busy), 64'd0);
      alu_wen = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
      step();
      alu_wen = 1'b0;
      chk("x0_alu_wen", 64'(RegWEn), 64'd0);
      resp(32'h66);
      chk("x0_ld_wen", 64'(RegWEn), 64'd0);
      chk("x0_err", 64'(wb_err), 64'd3);
      // reset with loads outstanding
      rs1_addr = 5'd20;
      issue(5'd20);
      issue(5'd21);
      chk("pre_rst_busy", 64'(rs1_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(rs1_busy), 64'd0);
      chk("arst_err", 64'(wb_err), 64'd0);
      chk("arst_rdy", 64'(ld_issue_ready), 64'd1);
      step();
      rst_n = 1'b1;
      step();
      resp(32'h77);
      chk("post_rst_orphan", 64'(wb_err), 64'd2);
      for (int i = 0; i < 4; i++) step();
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
